accum_zone_ctrl: RTL and testbench

Zone-side responder for the accumulator command/data protocol. It terminates one router output port and executes its write, accumulate-write and read commands against that zone's NUM_BANKS single-port SRAM banks. It returns read data with `rvalid` and applies backpressure through `wr_ready` and `rd_ready` while an accumulate read-modify-write is in flight. One instance sits behind each router zone port.

---
 rtl/accum_zone_if.sv | 37 +++
 rtl/accum_zone_ctrl.sv | 163 ++++++++++++++++
 tb/tb_accum_zone_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accum_zone_if.sv
// Command/read-return bundle between a router zone port and accum_zone_ctrl.
// The router side drives commands (master); the zone controller answers (slave).
interface accum_zone_if #(
    parameter int NUM_BANKS  = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8,
    parameter int ZONE_WIDTH = 2
);
    // valid/ready: a command transfers on a rising edge where valid and ready are both high;
    // valid and payload are held until then. rvalid/rdata have no backpressure.
    logic                             wr_valid;
    logic                             wr_ready;
    logic [ZONE_WIDTH-1:0]            wr_zone_id;
    logic                             accum_en;
    logic [NUM_BANKS-1:0]             wr_mask;
    logic [ADDR_WIDTH-1:0]            wr_addr;
    logic [NUM_BANKS*DATA_WIDTH-1:0]  wdata;
    logic                             rd_valid;
    logic                             rd_ready;
    logic [ZONE_WIDTH-1:0]            rd_zone_id;
    logic [NUM_BANKS-1:0]             rd_mask;
    logic [ADDR_WIDTH-1:0]            rd_addr;
    logic                             rvalid;
    logic [NUM_BANKS*DATA_WIDTH-1:0]  rdata;

    modport master (
        output wr_valid, wr_zone_id, accum_en, wr_mask, wr_addr, wdata,
        output rd_valid, rd_zone_id, rd_mask, rd_addr,
        input  wr_ready, rd_ready, rvalid, rdata
    );

    modport slave (
        input  wr_valid, wr_zone_id, accum_en, wr_mask, wr_addr, wdata,
        input  rd_valid, rd_zone_id, rd_mask, rd_addr,
        output wr_ready, rd_ready, rvalid, rdata
    );
endinterface

// File: rtl/accum_zone_ctrl.sv
// Zone responder: executes write / accumulate-write / read commands on NUM_BANKS single-port banks.
// Optional macro ACCUM_ZONE_ID_CHECK_EN enables zone-id checking and the sticky zone_err flag.
module accum_zone_ctrl #(
    parameter int NUM_BANKS  = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8,
    parameter int ZONE_WIDTH = 2,
    parameter int ZONE_ID    = 0
) (
    input  logic                            clk,
    input  logic                            rstn,
    accum_zone_if.slave                     bus,
    output logic [NUM_BANKS-1:0]            bank_en,
    output logic [NUM_BANKS-1:0]            bank_we,
    output logic [ADDR_WIDTH-1:0]           bank_addr,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] bank_wdata,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] bank_rdata,
    output logic                            zone_err,
    output logic [1:0]                      o_dbg_state
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACC_RD = 2'd1,
        ST_ACC_WR = 2'd2
    } state_t;

    localparam int LW = NUM_BANKS * DATA_WIDTH;

    state_t                r_state;
    logic                  r_last_grant;  // 1 = write granted last, 0 = read
    logic [NUM_BANKS-1:0]  r_mask_q;
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic [LW-1:0]         r_wdata_q;
    logic [LW-1:0]         r_sum_q;
    logic                  r_rvalid;
    logic [NUM_BANKS-1:0]  r_rd_mask;

    logic                  w_idle;
    logic                  w_wr_ready;
    logic                  w_rd_ready;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_wr_zone_ok;
    logic                  w_rd_zone_ok;
    logic                  w_wr_do;
    logic                  w_rd_do;
    logic [LW-1:0]         w_sum;
    logic [LW-1:0]         w_rdata;

    assign w_idle     = rstn && (r_state == ST_IDLE);
    assign w_wr_ready = w_idle && (!bus.rd_valid || !r_last_grant);
    assign w_rd_ready = w_idle && (!bus.wr_valid ||  r_last_grant);
    assign w_wr_acc   = bus.wr_valid && w_wr_ready;
    assign w_rd_acc   = bus.rd_valid && w_rd_ready;

`ifdef ACCUM_ZONE_ID_CHECK_EN
    logic r_zone_err;

    assign w_wr_zone_ok = (bus.wr_zone_id == ZONE_WIDTH'(ZONE_ID));
    assign w_rd_zone_ok = (bus.rd_zone_id == ZONE_WIDTH'(ZONE_ID));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_zone_err <= 1'b0;
        end else if ((w_wr_acc && !w_wr_zone_ok) || (w_rd_acc && !w_rd_zone_ok)) begin
            r_zone_err <= 1'b1;
        end
    end

    assign zone_err = r_zone_err;
`else
    logic w_unused_zone;

    assign w_unused_zone = ^{bus.wr_zone_id, bus.rd_zone_id};
    assign w_wr_zone_ok  = 1'b1;
    assign w_rd_zone_ok  = 1'b1;
    assign zone_err      = 1'b0;
`endif

    // A mismatched command is handshaked but never reaches the banks.
    assign w_wr_do = w_wr_acc && w_wr_zone_ok;
    assign w_rd_do = w_rd_acc && w_rd_zone_ok;

    always_comb begin
        w_sum   = '0;
        w_rdata = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_sum[b*DATA_WIDTH +: DATA_WIDTH] = bank_rdata[b*DATA_WIDTH +: DATA_WIDTH]
                                              + r_wdata_q[b*DATA_WIDTH +: DATA_WIDTH];
            if (r_rd_mask[b]) begin
                w_rdata[b*DATA_WIDTH +: DATA_WIDTH] = bank_rdata[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Bank port decode; everything is forced low while reset is asserted.
    always_comb begin
        bank_en    = '0;
        bank_we    = '0;
        bank_addr  = '0;
        bank_wdata = '0;
        if (rstn && (r_state == ST_ACC_WR)) begin
            bank_en    = r_mask_q;
            bank_we    = r_mask_q;
            bank_addr  = r_addr_q;
            bank_wdata = r_sum_q;
        end else if (w_wr_do) begin
            bank_en    = bus.wr_mask;
            bank_we    = bus.accum_en ? '0 : bus.wr_mask;
            bank_addr  = bus.wr_addr;
            bank_wdata = bus.wdata;
        end else if (w_rd_do) begin
            bank_en    = bus.rd_mask;
            bank_addr  = bus.rd_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b0;
            r_mask_q     <= '0;
            r_addr_q     <= '0;
            r_wdata_q    <= '0;
            r_sum_q      <= '0;
            r_rvalid     <= 1'b0;
            r_rd_mask    <= '0;
        end else begin
            r_rvalid  <= w_rd_acc;
            // Mask gates rdata; a mismatched or absent read leaves it zero.
            r_rd_mask <= w_rd_do ? bus.rd_mask : '0;
            if (w_wr_acc || w_rd_acc) begin
                r_last_grant <= w_wr_acc;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_do && bus.accum_en) begin
                        r_mask_q  <= bus.wr_mask;
                        r_addr_q  <= bus.wr_addr;
                        r_wdata_q <= bus.wdata;
                        r_state   <= ST_ACC_RD;
                    end
                end
                ST_ACC_RD: begin
                    r_sum_q <= w_sum;
                    r_state <= ST_ACC_WR;
                end
                ST_ACC_WR: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.wr_ready = w_wr_ready;
    assign bus.rd_ready = w_rd_ready;
    assign bus.rvalid   = r_rvalid;
    assign bus.rdata    = w_rdata;
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_accum_zone_ctrl.sv
// Directed bench for accum_zone_ctrl with a behavioural 1-cycle SRAM per bank and a read scoreboard.
module tb_accum_zone_ctrl;
`ifdef ACCUM_ZONE_ID_CHECK_EN
    localparam int TB_ZONE = 1;
`else
    localparam int TB_ZONE = 0;
`endif

    logic         clk;
    logic         rstn;
    logic [3:0]   bank_en;
    logic [3:0]   bank_we;
    logic [7:0]   bank_addr;
    logic [255:0] bank_wdata;
    logic [255:0] bank_rdata;
    logic         zone_err;
    logic [1:0]   dbg_state;

    int tests_run = 0;
    int tests_failed = 0;
    logic [255:0] exp_q[$];

    logic [3:0]   cap_en;
    logic [3:0]   cap_we;
    logic [7:0]   cap_addr;
    logic [255:0] cap_wdata;

    accum_zone_if #(.NUM_BANKS(4), .DATA_WIDTH(64), .ADDR_WIDTH(8), .ZONE_WIDTH(2)) bus ();

    accum_zone_ctrl #(
        .NUM_BANKS(4), .DATA_WIDTH(64), .ADDR_WIDTH(8), .ZONE_WIDTH(2), .ZONE_ID(TB_ZONE)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .bus         (bus),
        .bank_en     (bank_en),
        .bank_we     (bank_we),
        .bank_addr   (bank_addr),
        .bank_wdata  (bank_wdata),
        .bank_rdata  (bank_rdata),
        .zone_err    (zone_err),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- SRAM model: unwritten words return a fixed pattern ----------------
    function automatic logic [63:0] prior(input int b, input logic [7:0] a);
        return 64'hA000_0000_0000_0000 | (64'(b) << 8) | 64'(a);
    endfunction

    logic [63:0]      mem [4][256];
    logic [3:0][255:0] wr_flag = '0;

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bank_en[b]) begin
                if (bank_we[b]) begin
                    mem[b][bank_addr]     <= bank_wdata[b*64 +: 64];
                    wr_flag[b][bank_addr] <= 1'b1;
                end else begin
                    bank_rdata[b*64 +: 64] <= wr_flag[b][bank_addr] ? mem[b][bank_addr]
                                                                   : prior(b, bank_addr);
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.rvalid) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_rvalid: got rdata %h expected no return", bus.rdata);
            end else begin
                chk("rdata", bus.rdata, exp_q.pop_front());
            end
        end
    end

    task automatic chk_reset_outputs(input logic [1:0] exp_state);
        chk("rst_wr_ready", 256'(bus.wr_ready), 256'(1'b0));
        chk("rst_rd_ready", 256'(bus.rd_ready), 256'(1'b0));
        chk("rst_rvalid", 256'(bus.rvalid), 256'(1'b0));
        chk("rst_rdata", bus.rdata, 256'd0);
        chk("rst_bank_en", 256'(bank_en), 256'd0);
        chk("rst_bank_we", 256'(bank_we), 256'd0);
        chk("rst_bank_addr", 256'(bank_addr), 256'd0);
        chk("rst_bank_wdata", bank_wdata, 256'd0);
        chk("rst_zone_err", 256'(zone_err), 256'd0);
        chk("rst_state", 256'(dbg_state), 256'(exp_state));
    endtask

    // ---------------- drivers (entered and left at posedge+1) ----------------
    task automatic issue_wr(input logic [7:0] addr, input logic [3:0] mask, input logic [255:0] data,
                            input logic accum, input logic [1:0] zid);
        bit got = 0;
        bus.wr_valid   = 1'b1;
        bus.wr_addr    = addr;
        bus.wr_mask    = mask;
        bus.wdata      = data;
        bus.accum_en   = accum;
        bus.wr_zone_id = zid;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.wr_ready) begin
                got = 1;
                break;
            end
        end
        chk("wr_accept", 256'(got), 256'(1'b1));
        cap_en    = bank_en;
        cap_we    = bank_we;
        cap_addr  = bank_addr;
        cap_wdata = bank_wdata;
        @(posedge clk);
        #1;
        bus.wr_valid = 1'b0;
    endtask

    task automatic issue_rd(input logic [7:0] addr, input logic [3:0] mask, input logic [1:0] zid,
                            input logic [255:0] exp);
        bit got = 0;
        bus.rd_valid   = 1'b1;
        bus.rd_addr    = addr;
        bus.rd_mask    = mask;
        bus.rd_zone_id = zid;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.rd_ready) begin
                got = 1;
                break;
            end
        end
        chk("rd_accept", 256'(got), 256'(1'b1));
        if (got) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.rd_valid = 1'b0;
        @(negedge clk);
        chk("rd_latency", 256'(bus.rvalid), 256'(1'b1));
        @(posedge clk);
        #1;
    endtask

    localparam logic [1:0] ZN = 2'(TB_ZONE);

    // ---------------- stimulus ----------------
    initial begin
        rstn           = 1'b0;
        bus.wr_valid   = 1'b1;
        bus.rd_valid   = 1'b1;
        bus.accum_en   = 1'b0;
        bus.wr_mask    = 4'hF;
        bus.wr_addr    = 8'h55;
        bus.wdata      = {4{64'h1234}};
        bus.wr_zone_id = ZN;
        bus.rd_mask    = 4'hF;
        bus.rd_addr    = 8'h55;
        bus.rd_zone_id = ZN;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs(2'd0);
        @(posedge clk);
        #1;
        bus.wr_valid = 1'b0;
        bus.rd_valid = 1'b0;
        rstn         = 1'b1;

        // Plain masked write, then full / partial / empty reads.
        issue_wr(8'h10, 4'b0101, {64'd4, 64'd3, 64'd2, 64'd1}, 1'b0, ZN);
        chk("pw_bank_en", 256'(cap_en), 256'(4'b0101));
        chk("pw_bank_we", 256'(cap_we), 256'(4'b0101));
        chk("pw_bank_addr", 256'(cap_addr), 256'(8'h10));
        chk("pw_bank_wdata", cap_wdata, {64'd4, 64'd3, 64'd2, 64'd1});
        issue_rd(8'h10, 4'hF, ZN, {64'hA000_0000_0000_0310, 64'd3, 64'hA000_0000_0000_0110, 64'd1});
        issue_rd(8'h10, 4'b0101, ZN, {64'd0, 64'd3, 64'd0, 64'd1});
        issue_rd(8'h10, 4'b0000, ZN, 256'd0);

        // Accumulate 5 + 7.
        issue_wr(8'h20, 4'hF, {4{64'd5}}, 1'b0, ZN);
        issue_wr(8'h20, 4'hF, {4{64'd7}}, 1'b1, ZN);
        chk("acc_accept_en", 256'(cap_en), 256'(4'hF));
        chk("acc_accept_we", 256'(cap_we), 256'd0);
        @(negedge clk);
        chk("acc_rd_wr_ready", 256'(bus.wr_ready), 256'(1'b0));
        chk("acc_rd_rd_ready", 256'(bus.rd_ready), 256'(1'b0));
        chk("acc_rd_bank_en", 256'(bank_en), 256'd0);
        chk("acc_rd_state", 256'(dbg_state), 256'(2'd1));
        @(negedge clk);
        chk("acc_wr_wr_ready", 256'(bus.wr_ready), 256'(1'b0));
        chk("acc_wr_rd_ready", 256'(bus.rd_ready), 256'(1'b0));
        chk("acc_wr_bank_we", 256'(bank_we), 256'(4'hF));
        chk("acc_wr_bank_addr", 256'(bank_addr), 256'(8'h20));
        chk("acc_wr_bank_wdata", bank_wdata, {4{64'd12}});
        @(negedge clk);
        chk("acc_done_wr_ready", 256'(bus.wr_ready), 256'(1'b1));
        @(posedge clk);
        #1;
        issue_rd(8'h20, 4'hF, ZN, {4{64'd12}});

        // Wraparound on lane 0 only.
        issue_wr(8'h30, 4'hF, {64'd30, 64'd20, 64'd10, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b0, ZN);
        issue_wr(8'h30, 4'b0001, {64'd99, 64'd99, 64'd99, 64'd2}, 1'b1, ZN);
        issue_rd(8'h30, 4'hF, ZN, {64'd30, 64'd20, 64'd10, 64'd1});

        // Contention: last grant was a read, so writes lead and grants alternate.
        bus.wr_addr    = 8'h40;
        bus.wr_mask    = 4'hF;
        bus.wdata      = {64'd43, 64'd42, 64'd41, 64'd40};
        bus.accum_en   = 1'b0;
        bus.wr_zone_id = ZN;
        bus.rd_addr    = 8'h40;
        bus.rd_mask    = 4'hF;
        bus.rd_zone_id = ZN;
        bus.wr_valid   = 1'b1;
        bus.rd_valid   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("cont_wr_grant", 256'(bus.wr_ready), 256'(i % 2 == 0));
            chk("cont_rd_grant", 256'(bus.rd_ready), 256'(i % 2 == 1));
            if (bus.rd_ready) exp_q.push_back({64'd43, 64'd42, 64'd41, 64'd40});
            @(posedge clk);
            #1;
        end
        bus.wr_valid = 1'b0;
        bus.rd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset landing on the ACC_WR cycle drops the accumulate.
        issue_wr(8'h50, 4'hF, {4{64'd100}}, 1'b0, ZN);
        issue_wr(8'h50, 4'hF, {4{64'd50}}, 1'b1, ZN);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(negedge clk);
        chk_reset_outputs(2'd2);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_state", 256'(dbg_state), 256'(2'd0));
        chk("post_rst_bank_we", 256'(bank_we), 256'd0);
        @(posedge clk);
        #1;
        issue_rd(8'h50, 4'hF, ZN, {4{64'd100}});

        // Zone id handling.
        issue_wr(8'h60, 4'hF, {4{64'd9}}, 1'b0, 2'd2);
`ifdef ACCUM_ZONE_ID_CHECK_EN
        chk("zone_bad_wr_en", 256'(cap_en), 256'd0);
        @(negedge clk);
        chk("zone_err_set", 256'(zone_err), 256'(1'b1));
        @(posedge clk);
        #1;
        issue_rd(8'h60, 4'hF, 2'd2, 256'd0);
        issue_rd(8'h60, 4'hF, ZN, {64'hA000_0000_0000_0360, 64'hA000_0000_0000_0260,
                                   64'hA000_0000_0000_0160, 64'hA000_0000_0000_0060});
        chk("zone_err_sticky", 256'(zone_err), 256'(1'b1));
`else
        chk("zone_ignored_wr_en", 256'(cap_en), 256'(4'hF));
        issue_rd(8'h60, 4'hF, 2'd3, {4{64'd9}});
        chk("zone_err_tied", 256'(zone_err), 256'd0);
`endif

        repeat (3) @(posedge clk);
        chk("queue_drained", 256'(exp_q.size()), 256'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
